// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: canonical NOP, major opcodes and the
// fetch-unit state encoding.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_R_TYPE = 7'h33;
    localparam logic [6:0] OP_I_TYPE = 7'h13;
    localparam logic [6:0] OP_BRANCH = 7'h63;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } ifu_state_e;

    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return (low_bits != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Fetch program counter: synchronous reset to RESET_PC, redirect load, and
// sequential +4 step that wraps modulo 2^XLEN.
module fetch_pc_reg
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            inc,
    input  logic [XLEN-1:0] load_pc,
    output logic [XLEN-1:0] pc
);

    localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'd4};

    logic [XLEN-1:0] pc_r;

    // PC register: a redirect load outranks the sequential step
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r <= RESET_PC;
        end else if (load) begin
            pc_r <= load_pc;
        end else if (inc) begin
            pc_r <= pc_r + PC_STEP;
        end else begin
            pc_r <= pc_r;
        end
    end

    assign pc = pc_r;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding imem request, holds the fetched word for decode.
// Define IFU_MISALIGN_CHK_EN to add the fetch_misalign flag for unaligned redirects.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [31:0]     dec_instr,
    output logic [6:0]      dec_op,
    output logic [XLEN-1:0] dec_pc
`ifdef IFU_MISALIGN_CHK_EN
    ,
    output logic            fetch_misalign
`endif
);

    ifu_state_e      state_r, state_n;
    logic            kill_r, kill_n;
    logic            req_valid_r;
    logic            dec_valid_r, dec_valid_n;
    logic [31:0]     dec_instr_r, dec_instr_n;
    logic [XLEN-1:0] dec_pc_r, dec_pc_n;
    logic            pc_load_s, pc_inc_s;
    logic [XLEN-1:0] fetch_pc_s;
    logic [XLEN-1:0] target_s;

`ifdef IFU_MISALIGN_CHK_EN
    logic            misalign_r, misalign_n;
    assign target_s = redirect_pc;
`else
    // Without the checker the low two target bits are simply dropped.
    assign target_s = redirect_pc & ~{{(XLEN-2){1'b0}}, 2'b11};
`endif

    fetch_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_fetch_pc (
        .clk     (clk),
        .rst     (rst),
        .load    (pc_load_s),
        .inc     (pc_inc_s),
        .load_pc (target_s),
        .pc      (fetch_pc_s)
    );

    // Next-state and holding-register update; redirect outranks every handshake
    always_comb begin
        state_n     = state_r;
        kill_n      = kill_r;
        dec_valid_n = dec_valid_r;
        dec_instr_n = dec_instr_r;
        dec_pc_n    = dec_pc_r;
        pc_load_s   = 1'b0;
        pc_inc_s    = 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
        misalign_n  = misalign_r;
`endif
        case (state_r)
            REQ: begin
                if (redirect_valid) begin
                    pc_load_s = 1'b1;
                    if (req_valid_r && imem_req_ready) begin
                        state_n = WAIT;
                        kill_n  = 1'b1;
                    end else begin
                        state_n = REQ;
                    end
                end else if (req_valid_r && imem_req_ready) begin
                    state_n = WAIT;
                end else begin
                    state_n = REQ;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_load_s = 1'b1;
                    if (imem_rsp_valid) begin
                        kill_n  = 1'b0;
                        state_n = REQ;
                    end else begin
                        kill_n  = 1'b1;
                        state_n = WAIT;
                    end
                end else if (imem_rsp_valid) begin
                    if (kill_r) begin
                        kill_n  = 1'b0;
                        state_n = REQ;
                    end else begin
                        dec_valid_n = 1'b1;
                        dec_instr_n = imem_rsp_data;
                        dec_pc_n    = fetch_pc_s;
                        pc_inc_s    = 1'b1;
                        state_n     = HOLD;
                    end
                end else begin
                    state_n = WAIT;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    dec_valid_n = 1'b0;
                    dec_instr_n = NOP_INSTR;
                    pc_load_s   = 1'b1;
                    state_n     = REQ;
                end else if (dec_valid_r && dec_ready) begin
                    dec_valid_n = 1'b0;
                    dec_instr_n = NOP_INSTR;
                    state_n     = REQ;
                end else begin
                    state_n = HOLD;
                end
            end
            default: begin
                state_n     = REQ;
                kill_n      = 1'b0;
                dec_valid_n = 1'b0;
                dec_instr_n = NOP_INSTR;
            end
        endcase
`ifdef IFU_MISALIGN_CHK_EN
        // An unaligned target parks the unit with nothing valid until an aligned redirect.
        if (redirect_valid) begin
            if (is_misaligned(redirect_pc[1:0])) begin
                misalign_n  = 1'b1;
                pc_load_s   = 1'b0;
                pc_inc_s    = 1'b0;
                kill_n      = 1'b0;
                dec_valid_n = 1'b0;
                dec_instr_n = NOP_INSTR;
                state_n     = HOLD;
            end else begin
                misalign_n = 1'b0;
            end
        end else begin
            misalign_n = misalign_r;
        end
`endif
    end

    // State and holding registers; request valid is registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= REQ;
            kill_r      <= 1'b0;
            req_valid_r <= 1'b1;
            dec_valid_r <= 1'b0;
            dec_instr_r <= NOP_INSTR;
            dec_pc_r    <= RESET_PC;
        end else begin
            state_r     <= state_n;
            kill_r      <= kill_n;
            req_valid_r <= (state_n == REQ);
            dec_valid_r <= dec_valid_n;
            dec_instr_r <= dec_instr_n;
            dec_pc_r    <= dec_pc_n;
        end
    end

`ifdef IFU_MISALIGN_CHK_EN
    // Sticky misalignment flag
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_r <= 1'b0;
        end else begin
            misalign_r <= misalign_n;
        end
    end

    assign fetch_misalign = misalign_r;
`endif

    assign imem_req_valid = req_valid_r;
    assign imem_addr      = fetch_pc_s;
    assign dec_valid      = dec_valid_r;
    assign dec_instr      = dec_instr_r;
    assign dec_op         = dec_instr_r[6:0];
    assign dec_pc         = dec_pc_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: randomized memory/decoder/redirect
// traffic checked against an in-order "next PC" model, plus directed timing cases.
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid, dec_ready;
    logic [31:0] dec_instr;
    logic [6:0]  dec_op;
    logic [31:0] dec_pc;

    logic        w_req_valid, w_dec_valid;
    logic [31:0] w_addr, w_dec_instr, w_dec_pc;
    logic [6:0]  w_dec_op;
`ifdef IFU_MISALIGN_CHK_EN
    logic        fetch_misalign, w_misalign;
`endif

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr),
        .dec_op(dec_op), .dec_pc(dec_pc)
`ifdef IFU_MISALIGN_CHK_EN
        , .fetch_misalign(fetch_misalign)
`endif
    );

    // Wrap instance: always-ready memory answering every cycle, always-ready decoder.
    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req_valid(w_req_valid), .imem_req_ready(1'b1), .imem_addr(w_addr),
        .imem_rsp_valid(1'b1), .imem_rsp_data(32'h0000_0013),
        .redirect_valid(1'b0), .redirect_pc(32'h0000_0000),
        .dec_valid(w_dec_valid), .dec_ready(1'b1), .dec_instr(w_dec_instr),
        .dec_op(w_dec_op), .dec_pc(w_dec_pc)
`ifdef IFU_MISALIGN_CHK_EN
        , .fetch_misalign(w_misalign)
`endif
    );

    int total = 0;
    int bad = 0;
    int hs_count = 0;

    int ready_pct = 100;
    int lat_min = 0;
    int lat_max = 0;
    int stray_pct = 0;

    logic [31:0] mem_ovr [logic [31:0]];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return (a * 32'h9E37_79B1) ^ 32'h0000_5A13;
    endfunction

    function automatic logic [31:0] target_of(input logic [31:0] a);
`ifdef IFU_MISALIGN_CHK_EN
        return a;
`else
        return a & 32'hFFFF_FFFC;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s actual=timeout required=event t=%0t", name, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(input string name, input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) return;
        end
        timeout_fail(name);
    endtask

    task automatic wait_dec(input string name, input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (dec_valid) return;
        end
        timeout_fail(name);
    endtask

    // Memory responder: records accepted requests, answers after a random latency.
    initial begin
        logic        pend;
        logic [31:0] paddr;
        int          cnt;
        pend = 1'b0;
        paddr = 32'h0;
        cnt = 0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 1'b0;
            end else if (pend) begin
                if (imem_rsp_valid) pend = 1'b0;
            end else if (imem_req_valid && imem_req_ready) begin
                pend  = 1'b1;
                paddr = imem_addr;
                cnt   = $urandom_range(lat_max, lat_min);
            end
            @(posedge clk);
            #1;
            imem_req_ready = ($urandom_range(99) < ready_pct);
            if (pend && cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(paddr);
            end else if (pend) begin
                cnt--;
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = $urandom;
            end else begin
                imem_rsp_valid = ($urandom_range(99) < stray_pct);
                imem_rsp_data  = $urandom;
            end
        end
    end

    // Monitor/scoreboard: decoded words must appear in program order from the last redirect.
    initial begin
        logic [31:0] exp_q[$];
        logic [31:0] model_pc, e_pc, hold_instr, hold_pc;
        logic        hold_p;
        model_pc = 32'h0;
        hold_p = 1'b0;
        hold_instr = 32'h0;
        hold_pc = 32'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                model_pc = 32'h0;
                hold_p = 1'b0;
            end else begin
                if (hold_p) begin
                    check("hold_valid", dec_valid, 1'b1);
                    check("hold_instr", dec_instr, hold_instr);
                    check("hold_pc", dec_pc, hold_pc);
                end
                if (dec_valid) begin
                    check("dec_op", dec_op, dec_instr[6:0]);
                    check("no_fetch_in_hold", imem_req_valid, 1'b0);
                end
                if (dec_valid && dec_ready) begin
                    while (exp_q.size() < 4) begin
                        exp_q.push_back(model_pc);
                        model_pc = model_pc + 32'd4;
                    end
                    e_pc = exp_q.pop_front();
                    check("sb_pc", dec_pc, e_pc);
                    check("sb_instr", dec_instr, mem_word(e_pc));
                    hs_count++;
                end
                if (redirect_valid) begin
                    exp_q.delete();
                    model_pc = target_of(redirect_pc);
                end
                while (exp_q.size() < 4) begin
                    exp_q.push_back(model_pc);
                    model_pc = model_pc + 32'd4;
                end
                hold_p = dec_valid && !dec_ready && !redirect_valid;
                hold_instr = dec_instr;
                hold_pc = dec_pc;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    // Stimulus: directed timing cases, then randomized traffic, then mid-operation reset.
    initial begin
        int found;
        int saw_dv;
        int hs0;
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        dec_ready = 1'b1;
        mem_ovr[32'h0000_000C] = 32'h00A0_0093;
        mem_ovr[32'h0000_0010] = 32'hDEAD_BEEF;

        tick();
        tick();
        @(negedge clk);
        check("rst_dec_valid", dec_valid, 1'b0);
        check("rst_dec_instr", dec_instr, NOP);
        check("rst_dec_pc", dec_pc, 32'h0);
        check("rst_req_valid", imem_req_valid, 1'b1);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_wrap_addr", w_addr, 32'hFFFF_FFFC);
`ifdef IFU_MISALIGN_CHK_EN
        check("rst_misalign", fetch_misalign, 1'b0);
`endif

        // Zero-latency memory: one fetch every three cycles, wrap instance crosses 0.
        tick();
        rst = 1'b0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            check("t1_req_valid", imem_req_valid, (c % 3 == 0));
            check("t1_dec_valid", dec_valid, (c % 3 == 2));
            if (c % 3 == 0) check("t1_addr", imem_addr, 32'(4 * (c / 3)));
            if (c % 3 == 2) check("t1_dec_pc", dec_pc, 32'(4 * (c / 3)));
            if (c == 0) check("t6_wrap_first", w_addr, 32'hFFFF_FFFC);
            if (c == 2) check("t6_wrap_dec_pc", w_dec_pc, 32'hFFFF_FFFC);
            if (c == 3) begin
                check("t6_wrap_req", w_req_valid, 1'b1);
                check("t6_wrap_addr", w_addr, 32'h0);
            end
        end

        // Four-cycle memory: word visible to decode one cycle after the response.
        lat_min = 3;
        lat_max = 3;
        tick();
        dec_ready = 1'b0;
        found = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (imem_rsp_valid) begin
                found = i;
                break;
            end
        end
        if (found < 0) begin
            timeout_fail("t2_rsp");
        end else begin
            check("t2_rsp_latency", found, 4);
            check("t2_dv_before", dec_valid, 1'b0);
            @(negedge clk);
            check("t2_dec_valid", dec_valid, 1'b1);
            check("t2_dec_op", dec_op, 7'h13);
            check("t2_dec_instr", dec_instr, 32'h00A0_0093);
            check("t2_dec_pc", dec_pc, 32'h0000_000C);
        end

        // Decode stall: held word stable, no new request; release fetches dec_pc+4.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_hold_instr", dec_instr, 32'h00A0_0093);
            check("t3_hold_pc", dec_pc, 32'h0000_000C);
            check("t3_no_req", imem_req_valid, 1'b0);
        end
        lat_min = 5;
        lat_max = 5;
        tick();
        dec_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t3_next_req", imem_req_valid, 1'b1);
        check("t3_next_addr", imem_addr, 32'h0000_0010);

        // Redirect while waiting: late response discarded, refetch at target.
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0;
        saw_dv = 0;
        found = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (dec_valid) saw_dv = 1;
            if (imem_req_valid && imem_req_ready) begin
                found = 1;
                break;
            end
        end
        if (found == 0) timeout_fail("t4_refetch");
        check("t4_no_stale_word", saw_dv, 0);
        check("t4_addr", imem_addr, 32'h0000_0100);
        wait_dec("t4_dec", 30);
        check("t4_dec_pc", dec_pc, 32'h0000_0100);
        check("t4_dec_instr", dec_instr, mem_word(32'h0000_0100));

        // Redirect coinciding with the response, then redirect while holding.
        lat_min = 2;
        lat_max = 2;
        found = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #2;
            if (imem_rsp_valid) begin
                redirect_valid = 1'b1;
                redirect_pc = 32'h0000_0040;
                found = 1;
                break;
            end
        end
        if (found == 0) timeout_fail("t5_rsp");
        tick();
        redirect_valid = 1'b0;
        dec_ready = 1'b0;
        @(negedge clk);
        check("t5_req_valid", imem_req_valid, 1'b1);
        check("t5_addr", imem_addr, 32'h0000_0040);
        check("t5_dropped", dec_valid, 1'b0);
        wait_dec("t5_dec", 30);
        check("t5_dec_pc", dec_pc, 32'h0000_0040);
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0080;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("t5_hold_flush", dec_valid, 1'b0);
        check("t5_hold_nop", dec_instr, NOP);
        check("t5_hold_addr", imem_addr, 32'h0000_0080);
        check("t5_hold_req", imem_req_valid, 1'b1);
        tick();
        dec_ready = 1'b1;

`ifdef IFU_MISALIGN_CHK_EN
        tick();
        dec_ready = 1'b0;
        wait_dec("t6_mis_dec", 30);
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0102;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("t6_misalign_set", fetch_misalign, 1'b1);
        check("t6_misalign_dv", dec_valid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t6_misalign_no_req", imem_req_valid, 1'b0);
        end
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        dec_ready = 1'b1;
        @(negedge clk);
        check("t6_misalign_clear", fetch_misalign, 1'b0);
        check("t6_realign_req", imem_req_valid, 1'b1);
        check("t6_realign_addr", imem_addr, 32'h0000_0200);
`endif

        // Randomized traffic against the scoreboard.
        ready_pct = 60;
        lat_min = 0;
        lat_max = 4;
        stray_pct = 20;
        hs0 = hs_count;
        for (int i = 0; i < 3000; i++) begin
            tick();
            dec_ready = ($urandom_range(99) < 70);
            redirect_valid = ($urandom_range(99) < 5);
            redirect_pc = $urandom_range(1023);
`ifdef IFU_MISALIGN_CHK_EN
            redirect_pc = redirect_pc & 32'hFFFF_FFFC;
`endif
            rst = ($urandom_range(999) < 5);
        end
        tick();
        rst = 1'b0;
        redirect_valid = 1'b0;
        dec_ready = 1'b0;
        check("rand_progress", (hs_count - hs0) >= 100, 1'b1);

        // Mid-operation reset while holding, followed by stray responses.
        wait_dec("rst_mid_dec", 60);
        tick();
        rst = 1'b1;
        @(negedge clk);
        ready_pct = 0;
        stray_pct = 100;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_dec_valid", dec_valid, 1'b0);
        check("rst_mid_dec_instr", dec_instr, NOP);
        check("rst_mid_dec_pc", dec_pc, 32'h0);
        check("rst_mid_addr", imem_addr, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stray_ignored", dec_valid, 1'b0);
        end
        tick();
        ready_pct = 100;
        stray_pct = 0;
        lat_min = 0;
        lat_max = 0;
        dec_ready = 1'b1;
        wait_dec("rst_mid_refetch", 30);
        check("rst_mid_first_pc", dec_pc, 32'h0);
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
